// File: rtl/regfile_pkg.sv
// Shared constants and write-path state encoding for the register file.
package regfile_pkg;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 64;
  localparam int NUM_REGS = 1 << ADDR_W;
  localparam int ZERO_REG = 31;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } wr_state_t;

endpackage

// File: rtl/decoder_5to32.sv
// Combinational one-hot address decoder with enable; all-zero when disabled.
module decoder_5to32 #(
  parameter int ADDR_W = 5
) (
  input  logic                   en,
  input  logic [ADDR_W-1:0]      addr,
  output logic [(1<<ADDR_W)-1:0] onehot
);

  // One bit per register, selected by addr when enabled
  always_comb begin
    onehot = '0;
    if (en) onehot[addr] = 1'b1;
  end

endmodule

// File: rtl/regfile_write_demux.sv
// Write-side demux: valid/ready intake, one-entry skid buffer, registered
// one-hot word enable toward the register array. Writes to the zero
// register are swallowed and counted instead of being forwarded.
module regfile_write_demux
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = regfile_pkg::ADDR_W,
  parameter int DATA_W   = regfile_pkg::DATA_W,
  parameter int ZERO_REG = regfile_pkg::ZERO_REG
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ADDR_W-1:0]      in_addr,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   stall,
  output logic                   out_valid,
  output logic [(1<<ADDR_W)-1:0] en_out,
  output logic [ADDR_W-1:0]      out_addr,
  output logic [DATA_W-1:0]      data_out,
  output logic [7:0]             zero_wr_cnt
);

  localparam int NREGS = 1 << ADDR_W;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  wr_state_t             state, nxt_state;
  logic [ADDR_W-1:0]     skid_addr_p1;
  logic [DATA_W-1:0]     skid_data_p1;

  logic                  accept, is_zero, acc_wr;
  logic                  load_out_in, load_out_skid, load_skid_in;
  logic                  nxt_valid;
  logic [ADDR_W-1:0]     nxt_addr;
  logic [NREGS-1:0]      nxt_en;

  // in_ready comes straight from the state register
  assign in_ready = (state != SKID);
  assign accept   = in_valid & in_ready;
  assign is_zero  = (in_addr == ADDR_W'(ZERO_REG));
  assign acc_wr   = accept & ~is_zero;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= EMPTY;
    else       state <= nxt_state;
  end

  // Next state and load steering for output stage and skid entry
  always_comb begin
    nxt_state     = state;
    load_out_in   = 1'b0;
    load_out_skid = 1'b0;
    load_skid_in  = 1'b0;
    unique case (state)
      EMPTY: begin
        if (acc_wr) begin
          load_out_in = 1'b1;
          nxt_state   = FULL;
        end
      end
      FULL: begin
        if (!stall) begin
          if (acc_wr) load_out_in = 1'b1;
          else        nxt_state   = EMPTY;
        end else if (acc_wr) begin
          load_skid_in = 1'b1;
          nxt_state    = SKID;
        end
      end
      SKID: begin
        if (!stall) begin
          load_out_skid = 1'b1;
          nxt_state     = FULL;
        end
      end
      default: nxt_state = EMPTY;
    endcase
  end

  // Address that the output stage will hold after this edge
  always_comb begin
    nxt_addr = out_addr;
    if (load_out_in)        nxt_addr = in_addr;
    else if (load_out_skid) nxt_addr = skid_addr_p1;
  end

  assign nxt_valid = (nxt_state != EMPTY);

  decoder_5to32 #(.ADDR_W(ADDR_W)) u_dec (
    .en     (nxt_valid),
    .addr   (nxt_addr),
    .onehot (nxt_en)
  );

  // ---- stage p1: output register and skid entry ----
  // Output stage and skid buffer; contents are dropped on reset
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid    <= 1'b0;
      en_out       <= '0;
      out_addr     <= '0;
      data_out     <= '0;
      skid_addr_p1 <= '0;
      skid_data_p1 <= '0;
    end else begin
      out_valid <= nxt_valid;
      en_out    <= nxt_en;
      out_addr  <= nxt_addr;
      if (load_out_in)        data_out <= in_data;
      else if (load_out_skid) data_out <= skid_data_p1;
      if (load_skid_in) begin
        skid_addr_p1 <= in_addr;
        skid_data_p1 <= in_data;
      end
    end
  end

  // Saturating count of accepted zero-register writes
  always_ff @(posedge clk) begin
    if (reset)                zero_wr_cnt <= 8'd0;
    else if (accept & is_zero) zero_wr_cnt <= sat_inc(zero_wr_cnt);
  end

endmodule

// File: tb/tb_regfile_write_demux.sv
// Randomized scoreboard bench for regfile_write_demux.
module tb_regfile_write_demux;

  localparam int AW = 5;
  localparam int DW = 64;
  localparam int NR = 32;
  localparam logic [AW-1:0] ZR = 5'd31;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic          stall;
  logic          out_valid;
  logic [NR-1:0] en_out;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] data_out;
  logic [7:0]    zero_wr_cnt;

  regfile_write_demux dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_addr     (in_addr),
    .in_data     (in_data),
    .stall       (stall),
    .out_valid   (out_valid),
    .en_out      (en_out),
    .out_addr    (out_addr),
    .data_out    (data_out),
    .zero_wr_cnt (zero_wr_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  // Reference model: writes held by the block, in acceptance order
  wr_t sb[$];
  int  zcnt;
  bit  pend_zero;
  bit  started;
  int  nvec;
  int  nerr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; inputs change on the falling edge
  task automatic step(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic s, input logic r);
    wr_t w;
    bit  ready_m;
    @(negedge clk);
    in_valid = v; in_addr = a; in_data = d; stall = s; reset = r;
    #1;
    if (pend_zero) begin
      if (zcnt < 255) zcnt++;
      pend_zero = 1'b0;
    end
    ready_m = (sb.size() < 2);
    if (started) begin
      chk("in_ready", in_ready, ready_m);
      chk("out_valid", out_valid, sb.size() != 0);
    end
    if (r) begin
      sb.delete();
      zcnt = 0;
    end else if (v && ready_m) begin
      if (a == ZR) pend_zero = 1'b1;
      else begin
        w.addr = a; w.data = d;
        sb.push_back(w);
      end
    end
    if (r) started = 1'b1;
  endtask

  // Monitor: compares the presented write against the oldest expected one
  always @(negedge clk) begin
    #2;
    if (started && !reset) begin
      chk("en_out_zero_reg", en_out[ZR], 1'b0);
      chk("zero_wr_cnt", zero_wr_cnt, zcnt);
      if (out_valid) begin
        if (sb.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL unexpected_write: got addr %0d data %0h expected none", out_addr, data_out);
        end else begin
          chk("out_addr", out_addr, sb[0].addr);
          chk("data_out", data_out, sb[0].data);
          chk("en_out", en_out, 32'h1 << sb[0].addr);
          if (!stall) void'(sb.pop_front());
        end
      end else begin
        chk("en_out_idle", en_out, '0);
      end
    end
  end

  function automatic logic [DW-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    nvec = 0; nerr = 0; zcnt = 0; pend_zero = 0; started = 0;
    in_valid = 0; in_addr = '0; in_data = '0; stall = 0; reset = 1;

    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    // single write
    step(1, 5'd3, 64'hDEAD_BEEF_0000_0001, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    // back-to-back
    for (int i = 0; i < 3; i++) step(1, AW'(i), rnd64(), 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    // stall absorbs one into skid
    step(1, 5'd5, rnd64(), 1, 0);
    step(1, 5'd6, rnd64(), 1, 0);
    step(1, 5'd10, rnd64(), 1, 0);
    step(1, 5'd10, rnd64(), 1, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    // zero-register flood, saturation
    for (int i = 0; i < 300; i++) step(1, ZR, rnd64(), 1'($urandom_range(0, 1)), 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    // reset while in SKID
    step(1, 5'd7, rnd64(), 1, 0);
    step(1, 5'd8, rnd64(), 1, 0);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    // mixed stream with zero register in the middle
    step(1, 5'd4, rnd64(), 0, 0);
    step(1, ZR, rnd64(), 0, 0);
    step(1, 5'd9, rnd64(), 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [AW-1:0] a;
      a = ($urandom_range(0, 7) == 0) ? ZR : AW'($urandom);
      step(1'($urandom_range(0, 3) != 0), a, rnd64(),
           1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 199) == 0));
    end
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0);
    chk("drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
